// File: rtl/lift_pkg.sv
// ----------------------------------------------------------------------------
// lift_pkg
//   Shared definitions for the 5/3 lifting row sequencer:
//   - default address / sample widths of the pixel RAM bank
//   - sequencer state enum (also exported on the debug state output)
//   - pass encoding: PASS_ODD (predict) = 1, PASS_EVEN (update) = 0
//   - helper returning the first pass of a run for a given direction
// ----------------------------------------------------------------------------
package lift_pkg;

   localparam int LIFT_ADDR_W = 8;   // pixel RAM address width
   localparam int LIFT_DATA_W = 17;  // sample width, data never passes here

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      LAT  = 3'd2,
      CALC = 3'd3,
      WR   = 3'd4,
      FIN  = 3'd5
   } lift_state_e;

   localparam logic PASS_ODD  = 1'b1;
   localparam logic PASS_EVEN = 1'b0;

   // Forward transform predicts (odd pass) first; inverse undoes the update
   // (even pass) first.
   function automatic logic first_pass(input logic fwd);
      return fwd ? PASS_ODD : PASS_EVEN;
   endfunction

endpackage

// File: rtl/lift_addr_gen.sv
// ----------------------------------------------------------------------------
// lift_addr_gen
//   Combinational neighbour address generator with symmetric extension.
//   Ports:
//     idx_i        [ADDR_W:0]   centre sample index i
//     len_i        [ADDR_W:0]   row length (already known to be 2..2**ADDR_W)
//     addr_left_o  [ADDR_W-1:0] i-1, mirrored to 1 at i=0
//     addr_sam_o   [ADDR_W-1:0] i
//     addr_right_o [ADDR_W-1:0] i+1, mirrored to i-1 when i+1 >= len
// ----------------------------------------------------------------------------
module lift_addr_gen
   import lift_pkg::*;
#(
   parameter int ADDR_W = LIFT_ADDR_W
) (
   input  logic [ADDR_W:0]   idx_i,
   input  logic [ADDR_W:0]   len_i,
   output logic [ADDR_W-1:0] addr_left_o,
   output logic [ADDR_W-1:0] addr_sam_o,
   output logic [ADDR_W-1:0] addr_right_o
);

   // i+1 is kept one bit wider so the last index of a full-size row
   // does not wrap to 0 before the mirror comparison.
   logic [ADDR_W:0]   idx_p1;
   logic [ADDR_W-1:0] idx_m1;

   assign idx_p1 = idx_i + (ADDR_W+1)'(1);
   assign idx_m1 = idx_i[ADDR_W-1:0] - ADDR_W'(1);

   always_comb begin
      addr_sam_o   = idx_i[ADDR_W-1:0];
      addr_left_o  = (idx_i == '0) ? ADDR_W'(1) : idx_m1;
      addr_right_o = (idx_p1 >= len_i) ? idx_m1 : idx_p1[ADDR_W-1:0];
   end

endmodule

// File: rtl/lift_seq_ctrl.sv
// ----------------------------------------------------------------------------
// lift_seq_ctrl
//   Sequencer for one row of a 5/3 lifting step. Walks the two passes
//   (odd = predict, even = update) in direction-dependent order, 4 cycles
//   per sample: RD (addresses out) -> LAT (RAM latency) -> CALC (lift_vld)
//   -> WR (pix_we, addresses held).
//
//   Optional build macro: LIFT_PERF_CNT_EN adds perf_cycles[15:0], a
//   saturating count of busy cycles of the current/last run.
//
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     start                  1-cycle run request, honoured in IDLE only
//     fwd_inv                1=forward, 0=inverse, latched on start
//     row_len [ADDR_W:0]     samples in the row, latched on start
//     abort                  synchronous cancel, back to IDLE next cycle
//     addr_left/sam/right    RAM addresses for the current sample
//     pix_even_odd           current pass (1=odd, 0=even)
//     pix_fwd_inv            latched direction
//     lift_vld               datapath operands valid
//     pix_we                 write lifted result to addr_sam
//     busy, done, err        run status; err pulses with done on a bad length
//     dbg_state_o            current sequencer state
//     perf_cycles [15:0]     only with LIFT_PERF_CNT_EN
//
//   Handshake: start is a single-cycle request with no ready; it is accepted
//   only when the sequencer is in IDLE and is dropped otherwise. done (with
//   err) is a single-cycle pulse with no back-pressure.
// ----------------------------------------------------------------------------
module lift_seq_ctrl
   import lift_pkg::*;
#(
   parameter int ADDR_W = LIFT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              fwd_inv,
   input  logic [ADDR_W:0]   row_len,
   input  logic              abort,
   output logic [ADDR_W-1:0] addr_left,
   output logic [ADDR_W-1:0] addr_sam,
   output logic [ADDR_W-1:0] addr_right,
   output logic              pix_even_odd,
   output logic              pix_fwd_inv,
   output logic              lift_vld,
   output logic              pix_we,
   output logic              busy,
   output logic              done,
   output logic              err,
   output lift_state_e       dbg_state_o
`ifdef LIFT_PERF_CNT_EN
   ,
   output logic [15:0]       perf_cycles
`endif
);

   localparam logic [ADDR_W+1:0] MAX_LEN = (ADDR_W+2)'(1) << ADDR_W;

   lift_state_e     state_q, state_d;
   logic [ADDR_W:0] idx_q, idx_d;
   logic [ADDR_W:0] len_q, len_d;
   logic            pass_q, pass_d;
   logic            fwd_q, fwd_d;
   logic            second_q, second_d;  // currently in the second pass
   logic            err_q, err_d;        // run was rejected for its length

   logic            start_acc;
   logic            len_bad;
   logic            next_pass;
   logic            first_p;
   logic [ADDR_W:0] idx_next;

   logic [ADDR_W-1:0] gen_left, gen_sam, gen_right;

   assign start_acc = (state_q == IDLE) && start;
   assign len_bad   = (row_len < (ADDR_W+1)'(2)) || ({1'b0, row_len} > MAX_LEN);
   assign next_pass = ~pass_q;
   assign first_p   = first_pass(fwd_inv);
   assign idx_next  = idx_q + (ADDR_W+1)'(2);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      pass_d   = pass_q;
      fwd_d    = fwd_q;
      second_d = second_q;
      err_d    = err_q;
      lift_vld = 1'b0;
      pix_we   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               fwd_d = fwd_inv;
               len_d = row_len;
               if (len_bad) begin
                  err_d   = 1'b1;
                  state_d = FIN;
               end else begin
                  err_d    = 1'b0;
                  pass_d   = first_p;
                  // odd pass starts at index 1, even pass at 0
                  idx_d    = {{ADDR_W{1'b0}}, first_p};
                  second_d = 1'b0;
                  state_d  = RD;
               end
            end
         end
         RD: begin
            busy    = 1'b1;
            state_d = LAT;
         end
         LAT: begin
            busy    = 1'b1;
            state_d = CALC;
         end
         CALC: begin
            busy     = 1'b1;
            lift_vld = 1'b1;
            state_d  = WR;
         end
         WR: begin
            busy   = 1'b1;
            pix_we = 1'b1;
            if (idx_next < len_q) begin
               idx_d   = idx_next;
               state_d = RD;
            end else if (!second_q) begin
               // the next pass follows immediately with no gap cycle
               second_d = 1'b1;
               pass_d   = next_pass;
               idx_d    = {{ADDR_W{1'b0}}, next_pass};
               state_d  = RD;
            end else begin
               state_d = FIN;
            end
         end
         FIN: begin
            done    = 1'b1;
            err     = err_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         pix_we  = 1'b0;
         done    = 1'b0;
         err     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         pass_q   <= PASS_EVEN;
         fwd_q    <= 1'b0;
         second_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         pass_q   <= pass_d;
         fwd_q    <= fwd_d;
         second_q <= second_d;
         err_q    <= err_d;
      end
   end

   lift_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .idx_i        (idx_q),
      .len_i        (len_q),
      .addr_left_o  (gen_left),
      .addr_sam_o   (gen_sam),
      .addr_right_o (gen_right)
   );

   // Addresses read as 0 outside a run so idle/reset values are clean.
   assign addr_left    = busy ? gen_left  : '0;
   assign addr_sam     = busy ? gen_sam   : '0;
   assign addr_right   = busy ? gen_right : '0;
   assign pix_even_odd = pass_q;
   assign pix_fwd_inv  = fwd_q;
   assign dbg_state_o  = state_q;

`ifdef LIFT_PERF_CNT_EN
   logic [15:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (start_acc) begin
         perf_d = '0;
      end else if (busy && (perf_q != 16'hFFFF)) begin
         perf_d = perf_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`else
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_lift_seq_ctrl.sv
module tb_lift_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       fwd_inv;
   logic [8:0] row_len;
   logic       abort;
   logic [7:0] addr_left, addr_sam, addr_right;
   logic       pix_even_odd, pix_fwd_inv, lift_vld, pix_we, busy, done, err;
   logic [2:0] dbg_state;
`ifdef LIFT_PERF_CNT_EN
   logic [15:0] perf_cycles;
`endif

   int checks = 0;
   int fails  = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   lift_seq_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .fwd_inv      (fwd_inv),
      .row_len      (row_len),
      .abort        (abort),
      .addr_left    (addr_left),
      .addr_sam     (addr_sam),
      .addr_right   (addr_right),
      .pix_even_odd (pix_even_odd),
      .pix_fwd_inv  (pix_fwd_inv),
      .lift_vld     (lift_vld),
      .pix_we       (pix_we),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .dbg_state_o  (dbg_state)
`ifdef LIFT_PERF_CNT_EN
      ,
      .perf_cycles  (perf_cycles)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A run is the list of sample indices in visiting order; each sample
   // occupies 4 busy cycles, phase 2 = lift_vld, phase 3 = pix_we.
   int m_mode = 0;   // 0 idle, 1 running, 2 finishing (done cycle)
   int m_k, m_n, m_len;
   bit m_err, m_fwd;
   int m_seq[$];

   task automatic build_seq(input int len, input bit fwd);
      int first;
      m_seq.delete();
      first = fwd ? 1 : 0;
      for (int p = 0; p < 2; p++) begin
         for (int i = (p == 0) ? first : 1 - first; i < len; i += 2) m_seq.push_back(i);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0: if (start) begin
               m_fwd = fwd_inv;
               m_len = int'(row_len);
               if (m_len < 2 || m_len > 256) begin
                  m_err  = 1'b1;
                  m_mode = 2;
               end else begin
                  m_err = 1'b0;
                  build_seq(m_len, fwd_inv);
                  m_k    = 0;
                  m_n    = 4 * m_len;
                  m_mode = 1;
               end
            end
            1: begin
               if (abort) m_mode = 0;
               else if (m_k + 1 == m_n) m_mode = 2;
               else m_k++;
            end
            default: m_mode = 0;
         endcase
      end
   end

   // ---------------- observation logs ----------------
   logic [8:0] exp_q[$];
   int we_sam_q[$], we_left_q[$], we_right_q[$];
   int eo_q[$];
   int busy_cnt, done_cnt, err_cnt, done_at;

   task automatic clear_logs();
      exp_q.delete();
      we_sam_q.delete(); we_left_q.delete(); we_right_q.delete();
      eo_q.delete();
      busy_cnt = 0; done_cnt = 0; err_cnt = 0; done_at = -1;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      int idx, ph, e_sam, e_left, e_right;
      bit e_busy, e_done;
      e_busy = (m_mode == 1);
      e_done = (m_mode == 2) && !abort;
      idx = 0; ph = 0; e_sam = 0; e_left = 0; e_right = 0;
      if (e_busy) begin
         idx     = m_seq[m_k / 4];
         ph      = m_k % 4;
         e_sam   = idx;
         e_left  = (idx == 0) ? 1 : idx - 1;
         e_right = (idx + 1 >= m_len) ? idx - 1 : idx + 1;
      end
      chk("busy", busy, e_busy);
      chk("lift_vld", lift_vld, e_busy && ph == 2);
      chk("pix_we", pix_we, e_busy && ph == 3 && !abort);
      chk("done", done, e_done);
      chk("err", err, e_done && m_err);
      chk("addr_sam", addr_sam, e_sam);
      chk("addr_left", addr_left, e_left);
      chk("addr_right", addr_right, e_right);
      if (e_busy) chk("even_odd", pix_even_odd, idx % 2);
      if (m_mode != 0) chk("fwd_inv", pix_fwd_inv, m_fwd);

      if (busy) begin
         busy_cnt++;
         eo_q.push_back(int'(pix_even_odd));
      end
      if (pix_we) begin
         we_sam_q.push_back(int'(addr_sam));
         we_left_q.push_back(int'(addr_left));
         we_right_q.push_back(int'(addr_right));
      end
      if (done) begin
         done_cnt++;
         done_at = busy_cnt;
         if (err) err_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(input bit fwd, input int len);
      @(posedge clk); #1;
      start   = 1'b1;
      fwd_inv = fwd;
      row_len = len[8:0];
      @(posedge clk); #1;
      start   = 1'b0;
      fwd_inv = 1'($urandom_range(0, 1));
      row_len = 9'($urandom_range(0, 511));
   endtask

   task automatic wait_done(input int max);
      bit seen = 1'b0;
      for (int c = 0; c < max && !seen; c++) begin
         @(negedge clk); #2;
         if (done_cnt > 0) seen = 1'b1;
      end
      chk("done_timeout", seen, 1);
   endtask

   task automatic wait_busy(input int target, input int max);
      bit seen = 1'b0;
      for (int c = 0; c < max && !seen; c++) begin
         @(negedge clk); #2;
         if (busy_cnt >= target) seen = 1'b1;
      end
      chk("busy_timeout", seen, 1);
   endtask

   task automatic check_order();
      chk("we_count", we_sam_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < we_sam_q.size(); i++)
         chk("we_order", we_sam_q[i], exp_q[i]);
   endtask

   function automatic int find_right(input int sam);
      for (int i = 0; i < we_sam_q.size(); i++)
         if (we_sam_q[i] == sam) return we_right_q[i];
      return -1;
   endfunction

   function automatic int find_left(input int sam);
      for (int i = 0; i < we_sam_q.size(); i++)
         if (we_sam_q[i] == sam) return we_left_q[i];
      return -1;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int s;
      rst_n = 1'b0; start = 1'b0; fwd_inv = 1'b0; row_len = '0; abort = 1'b0;
      clear_logs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_addr_sam", addr_sam, 0);
      chk("rst_addr_left", addr_left, 0);
      chk("rst_addr_right", addr_right, 0);
      chk("rst_even_odd", pix_even_odd, 0);
      chk("rst_fwd_inv", pix_fwd_inv, 0);
      chk("rst_strobes", {lift_vld, pix_we, done, err}, 0);
      rst_n = 1'b1;
      idle(2);

      // forward, len 8
      clear_logs();
      exp_q = '{9'd1, 9'd3, 9'd5, 9'd7, 9'd0, 9'd2, 9'd4, 9'd6};
      do_start(1'b1, 8);
      wait_done(60);
      check_order();
      chk("f8_right7", find_right(7), 6);
      chk("f8_left0", find_left(0), 1);
      chk("f8_done_at", done_at, 32);
      chk("f8_err", err_cnt, 0);
      idle(2);
`ifdef LIFT_PERF_CNT_EN
      chk("perf_f8", perf_cycles, 32);
      idle(5);
      chk("perf_hold", perf_cycles, 32);
`endif

      // inverse, len 8
      clear_logs();
      exp_q = '{9'd0, 9'd2, 9'd4, 9'd6, 9'd1, 9'd3, 9'd5, 9'd7};
      do_start(1'b0, 8);
      wait_done(60);
      check_order();
      s = 0;
      for (int i = 0; i < 16 && i < eo_q.size(); i++) s += eo_q[i];
      chk("i8_eo_first16", s, 0);
      s = 0;
      for (int i = 16; i < eo_q.size(); i++) s += eo_q[i];
      chk("i8_eo_last16", s, 16);
      chk("i8_busy", busy_cnt, 32);
      idle(2);

      // forward, len 5
      clear_logs();
      exp_q = '{9'd1, 9'd3, 9'd0, 9'd2, 9'd4};
      do_start(1'b1, 5);
      wait_done(40);
      check_order();
      chk("f5_right4", find_right(4), 3);
      chk("f5_right3", find_right(3), 4);
      chk("f5_busy", busy_cnt, 20);
      idle(2);

      // invalid lengths 1 and 257, plus 0
      foreach (exp_q[i]) ;
      for (int t = 0; t < 3; t++) begin
         clear_logs();
         do_start(t[0], (t == 0) ? 1 : (t == 1) ? 257 : 0);
         wait_done(10);
         chk("bad_done", done_cnt, 1);
         chk("bad_err", err_cnt, 1);
         chk("bad_busy", busy_cnt, 0);
         chk("bad_we", we_sam_q.size(), 0);
         idle(2);
      end

      // abort in the 3rd sample's CALC (busy cycle index 10)
      clear_logs();
      do_start(1'b1, 8);
      wait_busy(11, 40);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      idle(8);
      chk("abort_we", we_sam_q.size(), 2);
      chk("abort_done", done_cnt, 0);
      chk("abort_busy_cnt", busy_cnt, 11);

      // clean run after abort
      clear_logs();
      exp_q = '{9'd1, 9'd3, 9'd0, 9'd2, 9'd4};
      do_start(1'b1, 5);
      wait_done(40);
      check_order();
      idle(2);

      // start pulsed mid-run is ignored
      clear_logs();
      exp_q = '{9'd0, 9'd2, 9'd4, 9'd1, 9'd3, 9'd5};
      do_start(1'b0, 6);
      wait_busy(10, 40);
      start = 1'b1; fwd_inv = 1'b1; row_len = 9'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(40);
      check_order();
      chk("ign_busy", busy_cnt, 24);
      idle(6);
      chk("ign_done_cnt", done_cnt, 1);
      chk("ign_busy_after", busy_cnt, 24);

      // full-size row, len 256
      clear_logs();
      do_start(1'b1, 256);
      wait_done(1100);
      chk("f256_we", we_sam_q.size(), 256);
      chk("f256_right255", find_right(255), 254);
      chk("f256_right254", find_right(254), 255);
      chk("f256_busy", busy_cnt, 1024);
      idle(2);

      // asynchronous reset mid-run
      clear_logs();
      do_start(1'b1, 8);
      wait_busy(7, 40);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_addr", {addr_left, addr_sam, addr_right}, 0);
      chk("arst_strobes", {lift_vld, pix_we, done, err}, 0);
      chk("arst_eo_fwd", {pix_even_odd, pix_fwd_inv}, 0);
`ifdef LIFT_PERF_CNT_EN
      chk("arst_perf", perf_cycles, 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // minimum valid length after reset
      clear_logs();
      exp_q = '{9'd1, 9'd0};
      do_start(1'b1, 2);
      wait_done(20);
      check_order();
      chk("f2_right1", find_right(1), 0);
      chk("f2_right0", find_right(0), 1);
      chk("f2_left0", find_left(0), 1);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
